// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: Wishbone classic bus bundle; master drives the request, slave returns data and ack.
interface wb_arbiter2_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    modport master (output addr, wdata, we, sel, stb, cyc, input rdata, ack);
    modport slave  (input addr, wdata, we, sel, stb, cyc, output rdata, ack);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone arbiter with whole-cycle ownership and a stalled-slave watchdog.
module wb_arbiter2 #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    wb_arbiter2_if.slave        m0,
    wb_arbiter2_if.slave        m1,
    wb_arbiter2_if.master       s,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);
    typedef enum logic [1:0] {IDLE, BUS_M0, BUS_M1, ABORT} state_t;
    state_t           state, next;
    logic             owner, last_owner, next_last;
    logic [CNT_W-1:0] wd, wd_next;
    logic             bus, cur_cyc, cur_stb, stall;
    assign bus     = (state == BUS_M0) || (state == BUS_M1);
    assign cur_cyc = owner ? m1.cyc : m0.cyc;
    assign cur_stb = owner ? m1.stb : m0.stb;
    assign stall   = bus && cur_stb && !s.ack;
    always_comb begin
        next      = state;
        next_last = last_owner;
        wd_next   = '0;
        case (state)
            IDLE:           next = (m0.cyc && (!m1.cyc || last_owner)) ? BUS_M0 : m1.cyc ? BUS_M1 : IDLE;
            BUS_M0, BUS_M1: begin
                if (!cur_cyc) begin
                    next      = IDLE;
                    next_last = owner;
                end else if (stall && wd == CNT_W'(TIMEOUT_CYCLES - 1)) next = ABORT;
                else if (stall) wd_next = wd + 1'b1;
            end
            default: begin
                next      = IDLE;
                next_last = owner;
            end
        endcase
    end
    // last_owner resets to M1 so M0 wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wd         <= '0;
        end else begin
            state      <= next;
            last_owner <= next_last;
            wd         <= wd_next;
            if (state == IDLE) owner <= (next == BUS_M1);
        end
    end
    assign s.addr  = bus ? (owner ? m1.addr : m0.addr) : '0;
    assign s.wdata = bus ? (owner ? m1.wdata : m0.wdata) : '0;
    assign s.we    = bus && (owner ? m1.we : m0.we);
    assign s.sel   = bus ? (owner ? m1.sel : m0.sel) : '0;
    assign s.stb   = bus && cur_stb;
    assign s.cyc   = bus && cur_cyc;
    // an aborted transfer is still acked so the master sees completion, with zero data
    assign m0.rdata = (state == BUS_M0) ? s.rdata : '0;
    assign m1.rdata = (state == BUS_M1) ? s.rdata : '0;
    assign m0.ack   = ((state == BUS_M0) && s.ack) || ((state == ABORT) && !owner);
    assign m1.ack   = ((state == BUS_M1) && s.ack) || ((state == ABORT) && owner);
    assign grant_o  = {(state == BUS_M1) || ((state == ABORT) && owner),
                       (state == BUS_M0) || ((state == ABORT) && !owner)};
    assign timeout_o = (state == ABORT);
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter that sits directly downstream of the CPU core.
- Master 0 is the core's data bus (dwishbone); master 1 is the instruction bus (iwishbone). It merges both onto a single slave port that feeds the RAM/peripheral interconnect.
- Provides round-robin arbitration with whole-cycle ownership.
- A bus watchdog aborts any transfer whose slave never acks, so a stalled slave cannot hang the pipeline's stall logic.

Parameters:
- TIMEOUT_CYCLES, 256: cycles a granted stb may wait for s_ack_i before abort; legal range 2..65535.
- CNT_W, 16: watchdog counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_addr_i / m1_addr_i  in  32  master address
- m0_data_i / m1_data_i  in  32  master write data
- m0_we_i / m1_we_i  in  1  write enable
- m0_sel_i / m1_sel_i  in  4  byte selects
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_cyc_i / m1_cyc_i  in  1  cycle (bus request)
- m0_data_o / m1_data_o  out  32  read data to master
- m0_ack_o / m1_ack_o  out  1  ack to master
- s_addr_o, s_data_o  out  32  slave address / write data
- s_we_o  out  1  slave write enable
- s_sel_o  out  4  slave byte selects
- s_stb_o, s_cyc_o  out  1  slave strobe / cycle
- s_data_i  in  32  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 when idle
- timeout_o  out  1  one-cycle pulse when a transfer is aborted

Behaviour:

Reset (rst=0, async):
- state=IDLE; last_owner=M1, so M0 wins the first tie; watchdog=0.
- Every output is 0: all data/addr/sel/we/stb/cyc/ack, grant_o=00, timeout_o=0.

State register: IDLE, BUS_M0, BUS_M1, ABORT. Owner, grant_o and state are registered. Datapath muxing is combinational from the registered owner.

IDLE:
- No slave signals driven (all 0); no acks.
- Next state:
  - m0_cyc_i & (!m1_cyc_i | last_owner==M1) -> BUS_M0
  - else m1_cyc_i -> BUS_M1
  - else stay in IDLE.
- Arbitration latency: 1 cycle from cyc to slave-side cyc.

BUS_Mx:
- s_* = mx_* passthrough.
- mx_data_o = s_data_i and mx_ack_o = s_ack_i, both combinational.
- Non-owner: data_o=0, ack_o=0. Its request is held, not dropped.
- Ownership persists while mx_cyc_i=1; back-to-back stb under one cyc stays granted.
- mx_cyc_i=0 -> IDLE and last_owner=x. This forces one IDLE cycle between owners and gives fair alternation.

Watchdog:
- Increments each cycle in BUS_Mx with s_stb_o=1 and s_ack_i=0.
- Clears on s_ack_i, on stb low, and on any state change.
- If the counter equals TIMEOUT_CYCLES-1 while stb=1 and s_ack_i=0 -> ABORT.
- The ack on the final cycle wins over the timeout: no abort.

ABORT (exactly 1 cycle):
- s_cyc_o=s_stb_o=0.
- Owner receives ack_o=1 with data_o=32'h0; timeout_o=1.
- Next state IDLE, last_owner=aborted owner.

Simultaneous and boundary cases:
- Both cyc rise in the same cycle: priority per last_owner.
- A master dropping cyc without an ack mid-transfer releases the bus next cycle; the slave sees cyc fall; no ack is generated.
- s_ack_i while IDLE or ABORT is ignored and not forwarded.
- Reset asserted mid-transfer drops all outputs immediately, asynchronously.

Test Plan:
1. Reset: rst=0 with both cyc high -> all outputs 0, grant_o=00. Release rst -> after 1 cycle grant_o=01, s_addr_o=m0_addr_i.
2. Single read: m1 cyc/stb, addr=32'h0000_0100, slave acks 2 cycles later with 32'hDEADBEEF -> m1_data_o=32'hDEADBEEF with m1_ack_o for 1 cycle; m0_ack_o stays 0.
3. Contention: both masters continuously issue single-beat cycles, dropping cyc after each ack -> grants alternate M0, M1, M0, M1 with one IDLE cycle between; no transfer lost.
4. Write passthrough: m0 we=1, sel=4'b0011, data=32'h1234_5678 -> identical values on s_* while granted; ack returned to m0 only.
5. Timeout: TIMEOUT_CYCLES=8, slave never acks m0 -> exactly 8 granted stb cycles, then ABORT with m0_ack_o=1, m0_data_o=0, timeout_o=1, s_cyc_o=0. Pending m1 is granted next. Slave ack on cycle 8 instead -> normal completion, timeout_o=0.
6. Mid-transfer reset: assert rst during BUS_M1 wait -> outputs 0 in the same cycle. After release, with only m1 requesting -> BUS_M1 granted in 1 cycle.
